// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the N-digit counter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_MAX_DIGITS = 8;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ZERO = 4'd0;

  // Force a non-decimal nibble (10..15) down to 9.
  function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp(input logic [BCD_DIGIT_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

  // True when every one of the low 'digits' nibbles holds 0..9.
  function automatic logic bcd_word_valid(input logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] w,
                                          input int unsigned digits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if ((i < digits) && (w[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_ud.sv
// Single BCD up/down digit with clear and clamped parallel load.
module bcd_digit_ud
  import bcd_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   up,
  input  logic                   clr,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] value,
  output logic [BCD_DIGIT_W-1:0] bcd,
  output logic                   co,
  output logic                   is9,
  output logic                   is0
);

  assign is9 = (bcd == BCD_MAX);
  assign is0 = (bcd == BCD_ZERO);
  // Carry when rolling 9->0 upward, borrow when rolling 0->9 downward.
  assign co  = up ? is9 : is0;

  // Digit register: reset > clr > load > step.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd <= BCD_ZERO;
    end else if (clr) begin
      bcd <= BCD_ZERO;
    end else if (load) begin
      bcd <= bcd_clamp(value);
    end else if (en) begin
      if (up) bcd <= is9 ? BCD_ZERO : bcd + 4'd1;
      else    bcd <= is0 ? BCD_MAX  : bcd - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_nd.sv
// N-digit BCD up/down counter with load, clear, saturate/wrap limits and
// terminal-count pulse. Optional sticky limit flag: BCD_COUNTER_ND_STICKY_OVF_EN.
module bcd_counter_nd
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          up,
  input  logic                          clr,
  input  logic                          load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] value,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          fs,
  output logic                          zero,
  output logic                          tc,
  output logic                          ovf
);

  localparam bit SATURATE = !WRAP;

  logic [DIGITS-1:0] co;
  logic [DIGITS-1:0] is9;
  logic [DIGITS-1:0] is0;
  logic [DIGITS-1:0] ripple;
  logic [DIGITS-1:0] dig_en;
  logic              count_req;
  logic              limit;
  logic              en_step;

  assign fs   = &is9;
  assign zero = &is0;

  // A step is requested only when nothing of higher priority is active.
  assign count_req = en & ~clr & ~load;
  // All digits carrying/borrowing at once is exactly the all-9s-up / all-0s-down limit.
  assign limit     = count_req & ripple[DIGITS-1] & co[DIGITS-1];
  assign en_step   = count_req & ~(limit & SATURATE);

  // Combinational carry/borrow chain so every digit moves on the same edge.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign ripple[i] = 1'b1;
    end else begin : g_rest
      assign ripple[i] = ripple[i-1] & co[i-1];
    end
    assign dig_en[i] = en_step & ripple[i];

    bcd_digit_ud u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (dig_en[i]),
      .up    (up),
      .clr   (clr),
      .load  (load),
      .value (value[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .bcd   (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .co    (co[i]),
      .is9   (is9[i]),
      .is0   (is0[i])
    );
  end

  // One-cycle terminal-count pulse for every limit event.
  always_ff @(posedge clk) begin
    if (reset) tc <= 1'b0;
    else       tc <= limit;
  end

`ifdef BCD_COUNTER_ND_STICKY_OVF_EN
  // Sticky limit flag; load leaves it alone, clr wins over a same-cycle limit.
  always_ff @(posedge clk) begin
    if (reset || clr) ovf <= 1'b0;
    else if (limit)   ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Self-checking bench: saturating 4-digit, wrapping 4-digit and wrapping 1-digit counters.
module tb_bcd_counter_nd;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, up, clr, load;
  logic [15:0] value;

  logic [15:0] bcd_s, bcd_w;
  logic [3:0]  bcd_1;
  logic        fs_s, zero_s, tc_s, ovf_s;
  logic        fs_w, zero_w, tc_w, ovf_w;
  logic        fs_1, zero_1, tc_1, ovf_1;

  bcd_counter_nd #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .value(value),
    .bcd(bcd_s), .fs(fs_s), .zero(zero_s), .tc(tc_s), .ovf(ovf_s));

  bcd_counter_nd #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .value(value),
    .bcd(bcd_w), .fs(fs_w), .zero(zero_w), .tc(tc_w), .ovf(ovf_w));

  bcd_counter_nd #(.DIGITS(1), .WRAP(1'b1)) u_one (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .value(value[3:0]),
    .bcd(bcd_1), .fs(fs_1), .zero(zero_1), .tc(tc_1), .ovf(ovf_1));

  always #5 clk = ~clk;

  typedef struct {
    bit r, c, l, e, u;
    logic [15:0] v;
    logic [15:0] bs; bit ts;
    logic [15:0] bw; bit tw;
  } vec_t;

  typedef struct {
    logic [15:0] bs; bit ts; bit os;
    logic [15:0] bw; bit tw; bit ow;
    logic [3:0]  b1; bit t1; bit o1;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int cur_s = 0, cur_w = 0, cur_1 = 0;
  bit ov_s = 0, ov_w = 0, ov_1 = 0;

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int m;
    m = n;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int r, mul;
    r = 0; mul = 1;
    for (int k = 0; k < 4; k++) begin
      r = r + int'(b[k*4 +: 4]) * mul;
      mul = mul * 10;
    end
    return r;
  endfunction

  function automatic int clamp_int(input logic [15:0] v, input int nd);
    int r, mul, d;
    r = 0; mul = 1;
    for (int k = 0; k < nd; k++) begin
      d = int'(v[k*4 +: 4]);
      if (d > 9) d = 9;
      r = r + d * mul;
      mul = mul * 10;
    end
    return r;
  endfunction

  // Reference behaviour in integer arithmetic.
  function automatic void model(input int maxv, input bit wrap, input int cur, input bit ov,
                                input bit r, input bit c, input bit l, input bit e, input bit u,
                                input int ldv, output int nxt, output bit tc, output bit nov);
    bit lim;
    lim = !r && !c && !l && e && (u ? (cur == maxv) : (cur == 0));
    tc  = lim;
    nxt = cur;
    if (r || c)   nxt = 0;
    else if (l)   nxt = ldv;
    else if (e) begin
      if (u) nxt = (cur == maxv) ? (wrap ? 0 : cur) : cur + 1;
      else   nxt = (cur == 0) ? (wrap ? maxv : 0) : cur - 1;
    end
`ifdef BCD_COUNTER_ND_STICKY_OVF_EN
    nov = (r || c) ? 1'b0 : (lim ? 1'b1 : ov);
`else
    nov = 1'b0;
`endif
  endfunction

  function automatic vec_t hv(input bit r, c, l, e, u, input logic [15:0] v,
                              input logic [15:0] bs, input bit ts,
                              input logic [15:0] bw, input bit tw);
    vec_t t;
    t.r = r; t.c = c; t.l = l; t.e = e; t.u = u; t.v = v;
    t.bs = bs; t.ts = ts; t.bw = bw; t.tw = tw;
    return t;
  endfunction

  // Vector whose 4-digit expectations come from the model.
  function automatic vec_t mv(input bit r, c, l, e, u, input logic [15:0] v);
    vec_t t;
    int ns, nw;
    bit ts, tw, d0, d1;
    model(9999, 1'b0, cur_s, ov_s, r, c, l, e, u, clamp_int(v, 4), ns, ts, d0);
    model(9999, 1'b1, cur_w, ov_w, r, c, l, e, u, clamp_int(v, 4), nw, tw, d1);
    t = hv(r, c, l, e, u, v, int2bcd(ns), ts, int2bcd(nw), tw);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    exp_t x, y;
    int   d, n1;
    bit   t1, o;
    reset = t.r; clr = t.c; load = t.l; en = t.e; up = t.u; value = t.v;
    model(9999, 1'b0, cur_s, ov_s, t.r, t.c, t.l, t.e, t.u, 0, d, t1, o);
    ov_s = o;
    model(9999, 1'b1, cur_w, ov_w, t.r, t.c, t.l, t.e, t.u, 0, d, t1, o);
    ov_w = o;
    model(9, 1'b1, cur_1, ov_1, t.r, t.c, t.l, t.e, t.u, clamp_int(t.v, 1), n1, t1, o);
    ov_1 = o;
    cur_s = bcd2int(t.bs);
    cur_w = bcd2int(t.bw);
    cur_1 = n1;
    x.bs = t.bs; x.ts = t.ts; x.os = ov_s;
    x.bw = t.bw; x.tw = t.tw; x.ow = ov_w;
    x.b1 = 4'(n1); x.t1 = t1; x.o1 = ov_1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk("bcd_sat",  32'(bcd_s),  32'(y.bs));
    chk("tc_sat",   32'(tc_s),   32'(y.ts));
    chk("fs_sat",   32'(fs_s),   32'(y.bs == 16'h9999));
    chk("zero_sat", 32'(zero_s), 32'(y.bs == 16'h0000));
    chk("ovf_sat",  32'(ovf_s),  32'(y.os));
    chk("bcd_wrap", 32'(bcd_w),  32'(y.bw));
    chk("tc_wrap",  32'(tc_w),   32'(y.tw));
    chk("fs_wrap",  32'(fs_w),   32'(y.bw == 16'h9999));
    chk("zero_wrap",32'(zero_w), 32'(y.bw == 16'h0000));
    chk("ovf_wrap", 32'(ovf_w),  32'(y.ow));
    chk("bcd_one",  32'(bcd_1),  32'(y.b1));
    chk("tc_one",   32'(tc_1),   32'(y.t1));
    chk("fs_one",   32'(fs_1),   32'(y.b1 == 4'd9));
    chk("zero_one", 32'(zero_1), 32'(y.b1 == 4'd0));
    chk("ovf_one",  32'(ovf_1),  32'(y.o1));
    chk("valid_sat",  32'(bcd_word_valid(32'(bcd_s), 4)), 32'd1);
    chk("valid_wrap", 32'(bcd_word_valid(32'(bcd_w), 4)), 32'd1);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; value = '0;
    #1;

    //              r  c  l  e  u  value     sat      tc  wrap     tc
    tbl.push_back(hv(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(hv(0, 0, 1, 0, 0, 16'h9998, 16'h9998, 0, 16'h9998, 0));
    tbl.push_back(hv(0, 0, 0, 1, 1, 16'h0000, 16'h9999, 0, 16'h9999, 0));
    tbl.push_back(hv(0, 0, 0, 1, 1, 16'h0000, 16'h9999, 1, 16'h0000, 1));
    tbl.push_back(hv(0, 0, 0, 1, 1, 16'h0000, 16'h9999, 1, 16'h0001, 0));
    tbl.push_back(hv(0, 0, 0, 1, 0, 16'h0000, 16'h9998, 0, 16'h0000, 0));
    tbl.push_back(hv(0, 0, 0, 1, 0, 16'h0000, 16'h9997, 0, 16'h9999, 1));
    tbl.push_back(hv(0, 0, 1, 1, 0, 16'h0999, 16'h0999, 0, 16'h0999, 0));
    tbl.push_back(hv(0, 0, 0, 1, 1, 16'h0000, 16'h1000, 0, 16'h1000, 0));
    tbl.push_back(hv(0, 0, 0, 1, 0, 16'h0000, 16'h0999, 0, 16'h0999, 0));
    tbl.push_back(hv(0, 1, 1, 1, 1, 16'h1234, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(hv(0, 0, 1, 0, 0, 16'h1234, 16'h1234, 0, 16'h1234, 0));
    tbl.push_back(hv(0, 0, 1, 0, 0, 16'hABCD, 16'h9999, 0, 16'h9999, 0));
    tbl.push_back(hv(0, 0, 1, 0, 1, 16'h0F3A, 16'h0939, 0, 16'h0939, 0));
    tbl.push_back(hv(0, 0, 1, 0, 0, 16'h4567, 16'h4567, 0, 16'h4567, 0));
    tbl.push_back(hv(0, 0, 0, 1, 1, 16'h0000, 16'h4568, 0, 16'h4568, 0));
    tbl.push_back(hv(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(hv(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'h9999, 1));
    tbl.push_back(hv(0, 0, 1, 0, 0, 16'h0500, 16'h0500, 0, 16'h0500, 0));
    tbl.push_back(hv(0, 0, 0, 1, 0, 16'h0000, 16'h0499, 0, 16'h0499, 0));
    tbl.push_back(hv(0, 0, 0, 0, 0, 16'h0000, 16'h0499, 0, 16'h0499, 0));
    tbl.push_back(hv(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(hv(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'h9999, 1));
    tbl.push_back(hv(0, 1, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(hv(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0));

    foreach (tbl[i]) drive(tbl[i]);

    // Full up-count from reset through saturation / wrap.
    drive(mv(1, 0, 0, 0, 1, 16'h0000));
    for (int i = 0; i < 10005; i++) drive(mv(0, 0, 0, 1, 1, 16'h0000));

    // Full down-count from all-9s, crossing the zero limit.
    drive(mv(0, 0, 1, 0, 0, 16'h9999));
    for (int i = 0; i < 10003; i++) drive(mv(0, 0, 0, 1, 0, 16'h0000));

    // Random mix of all controls.
    for (int i = 0; i < 400; i++) begin
      bit r, c, l, e, u;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = ($urandom_range(0, 1) == 1);
      drive(mv(r, c, l, e, u, 16'($urandom)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
